// File: rtl/tf_provider_gen.sv
// Twiddle-factor source: a quarter-wave cos/sin ROM folded into all four quadrants,
// streamed as IEEE-754 single {re, im} words with stride, hold, resync and conjugate mode.
module tf_provider_gen #(
  parameter int unsigned FLOAT_LEN   = 32,
  parameter int unsigned N_LOG2      = 13,
  parameter int unsigned TF_ADDR_LEN = 3,
  parameter int unsigned HOLD_LOG2   = 0,
  parameter string       ROM_INIT    = "tf_quarter.mem"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   frame_sync,
  input  logic                   inverse,
  output logic [2*FLOAT_LEN-1:0] data_out,
  output logic                   data_out_valid
);

  localparam int unsigned CNT_BITS  = TF_ADDR_LEN + HOLD_LOG2;
  localparam int unsigned CW        = (CNT_BITS > 0) ? CNT_BITS : 1;
  localparam int unsigned EXP_SHIFT = N_LOG2 - TF_ADDR_LEN;
  localparam int unsigned M_W       = N_LOG2 - 2;
  localparam int unsigned DEPTH     = 1 << M_W;
  localparam int unsigned WORD_W    = 2 * FLOAT_LEN;
  localparam logic [CW-1:0] CNT_MASK = {CW{1'b1}} >> (CW - CNT_BITS);

  // Sign-bit flip that never produces -0.
  function automatic logic [FLOAT_LEN-1:0] neg(input logic [FLOAT_LEN-1:0] x);
    if (x[FLOAT_LEN-2:0] == '0)
      return '0;
    return {~x[FLOAT_LEN-1], x[FLOAT_LEN-2:0]};
  endfunction

  // Elaboration-time double -> single conversion (round to nearest even) for
  // table values in [0, 1]; no subnormals occur for supported sizes.
  function automatic logic [FLOAT_LEN-1:0] real_to_f32(input real x);
    logic [63:0] d;
    logic [7:0]  ex;
    logic [23:0] man;
    logic [28:0] rest;
    d = $realtobits(x);
    if (d[62:0] == 63'd0)
      return '0;
    ex   = 8'(d[62:52] - 11'd896);
    man  = {1'b0, d[51:29]};
    rest = d[28:0];
    if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && man[0]))
      man = man + 24'd1;
    if (man[23]) begin
      man = '0;
      ex  = ex + 8'd1;
    end
    return {d[63], ex, man[22:0]};
  endfunction

  logic [WORD_W-1:0] rom [DEPTH];

  localparam real TWO_PI = 6.283185307179586;
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam real ANG = TWO_PI * real'(i) / real'(1 << N_LOG2);
    assign rom[i] = {real_to_f32($cos(ANG)), real_to_f32($sin(ANG))};
  end

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_used;
  logic [N_LOG2-1:0]    e;
  logic [1:0]           q;
  logic [M_W-1:0]       m;
  logic [1:0]           q_r;
  logic                 inv_r;
  logic                 v1;
  logic [WORD_W-1:0]    rom_rd;
  logic [FLOAT_LEN-1:0] c;
  logic [FLOAT_LEN-1:0] s;
  logic [FLOAT_LEN-1:0] cos_f;
  logic [FLOAT_LEN-1:0] sin_f;
  logic [FLOAT_LEN-1:0] im_f;

  always_comb begin
    cnt_used = frame_sync ? '0 : cnt;
    e        = N_LOG2'(cnt_used >> HOLD_LOG2) << EXP_SHIFT;
    q        = e[N_LOG2-1 -: 2];
    m        = e[M_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= (cnt_used + CW'(1)) & CNT_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= '0;
      inv_r <= 1'b0;
      v1    <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        q_r   <= q;
        inv_r <= inverse;
      end
    end
  end

  // ROM read register stays reset-free so it can map onto block RAM; v1 masks it.
  always_ff @(posedge clk) begin
    if (en)
      rom_rd <= rom[m];
  end

  always_comb begin
    c = rom_rd[WORD_W-1:FLOAT_LEN];
    s = rom_rd[FLOAT_LEN-1:0];
    case (q_r)
      2'd0: begin
        cos_f = c;
        sin_f = s;
      end
      2'd1: begin
        cos_f = neg(s);
        sin_f = c;
      end
      2'd2: begin
        cos_f = neg(c);
        sin_f = neg(s);
      end
      default: begin
        cos_f = s;
        sin_f = neg(c);
      end
    endcase
    im_f = inv_r ? sin_f : neg(sin_f);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= v1;
      if (v1)
        data_out <= {cos_f, im_f};
    end
  end

endmodule

// File: tb/tb_tf_provider_gen.sv
// Self-checking bench for tf_provider_gen: four configurations driven in parallel
// and compared against a sample-count / angle reference model.
module tb_tf_provider_gen;

    localparam int ND = 4;
    localparam real TWO_PI = 6.283185307179586;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic fs  = 1'b0;
    logic inv = 1'b0;
    logic [ND-1:0][63:0] dout;
    logic [ND-1:0]       vld;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tf_provider_gen #(.FLOAT_LEN(32), .N_LOG2(13), .TF_ADDR_LEN(3), .HOLD_LOG2(0), .ROM_INIT("")) dut_a (
        .clk(clk), .rst(rst), .en(en), .frame_sync(fs), .inverse(inv),
        .data_out(dout[0]), .data_out_valid(vld[0]));
    tf_provider_gen #(.FLOAT_LEN(32), .N_LOG2(13), .TF_ADDR_LEN(3), .HOLD_LOG2(2), .ROM_INIT("")) dut_b (
        .clk(clk), .rst(rst), .en(en), .frame_sync(fs), .inverse(inv),
        .data_out(dout[1]), .data_out_valid(vld[1]));
    tf_provider_gen #(.FLOAT_LEN(32), .N_LOG2(6), .TF_ADDR_LEN(6), .HOLD_LOG2(1), .ROM_INIT("")) dut_c (
        .clk(clk), .rst(rst), .en(en), .frame_sync(fs), .inverse(inv),
        .data_out(dout[2]), .data_out_valid(vld[2]));
    tf_provider_gen #(.FLOAT_LEN(32), .N_LOG2(4), .TF_ADDR_LEN(0), .HOLD_LOG2(0), .ROM_INIT("")) dut_d (
        .clk(clk), .rst(rst), .en(en), .frame_sync(fs), .inverse(inv),
        .data_out(dout[3]), .data_out_valid(vld[3]));

    int unsigned tl[ND] = '{3, 3, 6, 0};
    int unsigned hl[ND] = '{0, 2, 1, 0};

    // Exact forward twiddles for the eight angles k*45 degrees.
    logic [63:0] e8 [8] = '{
        64'h3F800000_00000000, 64'h3F3504F3_BF3504F3, 64'h00000000_BF800000, 64'hBF3504F3_BF3504F3,
        64'hBF800000_00000000, 64'hBF3504F3_3F3504F3, 64'h00000000_3F800000, 64'h3F3504F3_3F3504F3};

    // Reference model: enabled-sample count plus a two-deep delay line.
    int unsigned smp[ND];
    bit          p1v[ND], p2v[ND], p1i[ND], p2i[ND];
    int unsigned p1j[ND], p2j[ND];
    bit          ev[ND];
    bit          hz[ND];
    int unsigned hj[ND];
    bit          hi[ND];

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            smp[d] = 0;
            p1v[d] = 0;
            p2v[d] = 0;
            ev[d]  = 0;
            hz[d]  = 1;
        end
    endtask

    task automatic tick();
        int unsigned su;
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            p2v[d] = p1v[d];
            p2j[d] = p1j[d];
            p2i[d] = p1i[d];
            if (en) begin
                su     = fs ? 0 : smp[d];
                smp[d] = (su + 1) % (1 << (tl[d] + hl[d]));
                p1v[d] = 1;
                p1j[d] = su >> hl[d];
                p1i[d] = inv;
            end else begin
                p1v[d] = 0;
            end
            ev[d] = p2v[d];
            if (p2v[d]) begin
                hz[d] = 0;
                hj[d] = p2j[d];
                hi[d] = p2i[d];
            end
        end
        #1;
    endtask

    function automatic logic [63:0] exact_word(int d);
        logic [63:0] x;
        x = e8[hj[d]];
        if (hi[d] && x[31:0] != 32'h0)
            x[31] = ~x[31];
        return x;
    endfunction

    function automatic real exp_re(int d);
        return $cos(TWO_PI * real'(hj[d]) / real'(1 << tl[d]));
    endfunction

    function automatic real exp_im(int d);
        real sn;
        sn = $sin(TWO_PI * real'(hj[d]) / real'(1 << tl[d]));
        return hi[d] ? sn : -sn;
    endfunction

    function automatic real f2r(logic [31:0] b);
        if (b[30:0] == 31'h0)
            return 0.0;
        return (b[31] ? -1.0 : 1.0) * (1.0 + real'(b[22:0]) / 8388608.0)
               * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    endfunction

    // Zero must be bit-exact +0; anything else within single-precision rounding.
    function automatic bit near(logic [31:0] b, real x);
        real a;
        if (x < 1.0e-9 && x > -1.0e-9)
            return b === 32'h0;
        if ($isunknown(b))
            return 0;
        a = f2r(b);
        return (a - x) < 2.0e-7 && (x - a) < 2.0e-7;
    endfunction

    function automatic bit match(int d);
        if (hz[d])
            return dout[d] === 64'h0;
        if (d < 2)
            return dout[d] === exact_word(d);
        return near(dout[d][63:32], exp_re(d)) && near(dout[d][31:0], exp_im(d));
    endfunction

    function automatic string want_text(int d);
        if (hz[d])
            return "data=0000000000000000";
        if (d < 2)
            return $sformatf("data=%h", exact_word(d));
        return $sformatf("re=%f im=%f", exp_re(d), exp_im(d));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        fs  = 1'b0;
        model_reset();
        repeat (2) tick();
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (vld[d] !== 1'b0 || dout[d] !== 64'h0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got valid=%b data=%h, want valid=0 data=0", d, vld[d], dout[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic run_pattern(string tag, int n, bit en_v[$], bit fs_v[$], bit inv_v);
        for (int k = 0; k < n; k++) begin
            en  = (k < en_v.size()) ? en_v[k] : 1'b0;
            fs  = (k < fs_v.size()) ? fs_v[k] : 1'b0;
            inv = inv_v;
            tick();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (vld[d] !== ev[d] || !match(d)) begin
                    miscompares++;
                    $display("FAIL %s dut%0d cyc%0d: got valid=%b data=%h, want valid=%b %s",
                             tag, d, k, vld[d], dout[d], ev[d], want_text(d));
                end
            end
        end
        en = 1'b0;
        fs = 1'b0;
    endtask

    task automatic test_sequence();
        run_pattern("sequence", 13, '{1,1,1,1,1,1,1,1,1,1}, '{0}, 1'b0);
    endtask

    task automatic test_inverse();
        run_pattern("inverse", 13, '{1,1,1,1,1,1,1,1,1,1}, '{1}, 1'b1);
    endtask

    task automatic test_hold();
        run_pattern("hold", 19, '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1}, '{1}, 1'b0);
    endtask

    task automatic test_gaps();
        run_pattern("gaps", 9, '{1,0,1,0,1}, '{1}, 1'b0);
    endtask

    task automatic test_frame_sync();
        run_pattern("frame_sync", 12, '{1,1,1,1,1,1,1,0,1,1}, '{1,0,0,0,0,1,0,1,0,0}, 1'b0);
    endtask

    task automatic test_reset_inflight();
        en = 1'b1;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        tick();
        en = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (vld[d] !== 1'b0 || dout[d] !== 64'h0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got valid=%b data=%h, want valid=0 data=0", d, vld[d], dout[d]);
            end
        end
        #1 rst = 1'b0;
        run_pattern("after_reset", 5, '{0,1,0,0,0}, '{0}, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en  = ($urandom % 4) != 0;
            fs  = ($urandom % 16) == 0;
            inv = $urandom % 2;
            tick();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (vld[d] !== ev[d] || !match(d)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d: got valid=%b data=%h, want valid=%b %s",
                             d, k, vld[d], dout[d], ev[d], want_text(d));
                end
            end
        end
        en = 1'b0;
        fs = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_inverse();
        test_hold();
        test_gaps();
        test_frame_sync();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
